// File: rtl/tdoa_pkg.sv
// -----------------------------------------------------------------------------
// tdoa_pkg
// Shared definitions for the TDOA lag estimator:
//   MIC_NUM   number of surrounding microphones (one correlator lane each)
//   LAG_W     width of each signed lag output word
//   state_e   frame sequencing states
//   cnt_width counter width that holds a full frame of agreements
// -----------------------------------------------------------------------------
package tdoa_pkg;

  localparam int MIC_NUM = 6;
  localparam int LAG_W   = 32;

  typedef enum logic [1:0] {
    ACCUM,
    SEARCH,
    WAIT,
    EMIT
  } state_e;

  // Every sample of a frame can agree, so the counter must reach FRAME_LEN.
  function automatic int cnt_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/xcorr_lane.sv
// -----------------------------------------------------------------------------
// xcorr_lane
// One microphone pair of the sign-bit cross-correlator. Delays the mic sign by
// MAX_LAG samples, counts sign agreements against every reference tap, and
// scans the counters for the best-scoring lag index.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   sample_valid_i  shifts the mic delay line (in any state)
//   mic_sign_i      sign bit of the incoming mic sample
//   ref_taps_i      sign(ref[n-d]) for d = 0..2*MAX_LAG, current sample at d=0
//   acc_en_i        count agreements for the sample arriving this cycle
//   scan_en_i       compare counter[lag_idx_i] with the running best
//   lag_idx_i       lag index being scanned (lag = index - MAX_LAG)
//   clear_i         clear counters and best registers for the next frame
//   best_idx_o      index of the highest score seen so far
// -----------------------------------------------------------------------------
module xcorr_lane
  import tdoa_pkg::*;
#(
  parameter  int MAX_LAG = 6,
  parameter  int CNT_W   = 11,
  localparam int NLAG    = 2 * MAX_LAG + 1,
  localparam int IDX_W   = $clog2(NLAG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid_i,
  input  logic             mic_sign_i,
  input  logic [NLAG-1:0]  ref_taps_i,
  input  logic             acc_en_i,
  input  logic             scan_en_i,
  input  logic [IDX_W-1:0] lag_idx_i,
  input  logic             clear_i,
  output logic [IDX_W-1:0] best_idx_o
);

  // mic_line_q[j] = sign(mic[n-1-j]) before the shift, so the oldest entry is
  // sign(mic[n-MAX_LAG]) for the sample arriving this cycle.
  logic [MAX_LAG-1:0] mic_line_q;
  logic               mic_tap;
  logic [CNT_W-1:0]   cnt_q [NLAG];
  logic [CNT_W-1:0]   best_score_q;
  logic [IDX_W-1:0]   best_idx_q;

  assign mic_tap = mic_line_q[MAX_LAG-1];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      mic_line_q <= '0;
    end else if (sample_valid_i) begin
      mic_line_q[0] <= mic_sign_i;
      for (int j = 1; j < MAX_LAG; j++) mic_line_q[j] <= mic_line_q[j-1];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the counter array is reset explicitly; a reset mid-frame must
    // discard partial scores, so these stay flops rather than a RAM.
    if (rst || clear_i) begin
      for (int i = 0; i < NLAG; i++) cnt_q[i] <= '0;
    end else if (acc_en_i) begin
      for (int i = 0; i < NLAG; i++) begin
        if (mic_tap == ref_taps_i[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Strictly-greater replacement keeps the earliest (most negative) lag on ties.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      best_score_q <= '0;
      best_idx_q   <= '0;
    end else if (scan_en_i && (cnt_q[lag_idx_i] > best_score_q)) begin
      best_score_q <= cnt_q[lag_idx_i];
      best_idx_q   <= lag_idx_i;
    end
  end

  assign best_idx_o = best_idx_q;

endmodule

// File: rtl/tdoa_lag_estimator.sv
// -----------------------------------------------------------------------------
// tdoa_lag_estimator
// Sign-bit cross-correlation of a reference mic against six surrounding mics
// over a frame of FRAME_LEN samples; reports the best lag per pair and pulses
// ena to start the downstream position calculator.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   sample_valid   one-cycle strobe, new samples on mic_ref / mic_data
//   mic_ref        reference (centre) microphone, signed PCM
//   mic_data[k]    surrounding microphone k, signed PCM
//   pos_ready      downstream idle, may accept ena
//   lag_diff[k]    best lag for pair k, sign-extended, held until next ena
//   ena            one-cycle pulse, lag_diff updated this cycle
//   busy           high whenever the frame sequencer is not accumulating
//   overrun        sticky: a sample arrived while not accumulating
// -----------------------------------------------------------------------------
module tdoa_lag_estimator
  import tdoa_pkg::*;
#(
  parameter int SW        = 16,
  parameter int MAX_LAG   = 6,
  parameter int FRAME_LEN = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic signed [SW-1:0]    mic_ref,
  input  logic signed [SW-1:0]    mic_data [0:MIC_NUM-1],
  input  logic                    pos_ready,
  output logic signed [LAG_W-1:0] lag_diff [0:MIC_NUM-1],
  output logic                    ena,
  output logic                    busy,
  output logic                    overrun
);

  localparam int NLAG  = 2 * MAX_LAG + 1;
  localparam int IDX_W = $clog2(NLAG);
  localparam int CNT_W = cnt_width(FRAME_LEN);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       frame_cnt_q;
  logic [IDX_W-1:0]       lag_idx_q;
  logic [NLAG-2:0]        ref_hist_q;
  logic [NLAG-1:0]        ref_taps;
  logic                   busy_q, ena_q, overrun_q;
  logic signed [LAG_W-1:0] lag_q [MIC_NUM];
  logic [IDX_W-1:0]       best_idx [MIC_NUM];
  logic                   acc_en, scan_en, clear, load_out;
  logic [MIC_NUM:0]       unused_mag;

  // Tap d holds sign(ref[n-d]) for the sample arriving now: the live sign bit
  // is tap 0 and the stored history supplies taps 1..2*MAX_LAG.
  assign ref_taps = {ref_hist_q, mic_ref[SW-1]};

  // Only sign bits feed the correlator; magnitude bits are deliberately dropped.
  assign unused_mag[MIC_NUM] = ^mic_ref[SW-2:0];

  for (genvar k = 0; k < MIC_NUM; k++) begin : g_lane
    xcorr_lane #(
      .MAX_LAG (MAX_LAG),
      .CNT_W   (CNT_W)
    ) u_lane (
      .clk            (clk),
      .rst            (rst),
      .sample_valid_i (sample_valid),
      .mic_sign_i     (mic_data[k][SW-1]),
      .ref_taps_i     (ref_taps),
      .acc_en_i       (acc_en),
      .scan_en_i      (scan_en),
      .lag_idx_i      (lag_idx_q),
      .clear_i        (clear),
      .best_idx_o     (best_idx[k])
    );
    assign unused_mag[k] = ^mic_data[k][SW-2:0];
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_d  = state_q;
    acc_en   = 1'b0;
    scan_en  = 1'b0;
    clear    = 1'b0;
    load_out = 1'b0;
    unique case (state_q)
      ACCUM: begin
        if (sample_valid) begin
          acc_en = 1'b1;
          if (frame_cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = SEARCH;
        end
      end
      SEARCH: begin
        scan_en = 1'b1;
        if (lag_idx_q == IDX_W'(NLAG - 1)) state_d = WAIT;
      end
      WAIT: begin
        if (pos_ready) begin
          load_out = 1'b1;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        clear   = 1'b1;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      frame_cnt_q <= '0;
      lag_idx_q   <= '0;
      ref_hist_q  <= '0;
      busy_q      <= 1'b0;
      ena_q       <= 1'b0;
      overrun_q   <= 1'b0;
      for (int k = 0; k < MIC_NUM; k++) lag_q[k] <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ACCUM);
      ena_q   <= load_out;

      if (sample_valid) ref_hist_q <= ref_taps[NLAG-2:0];
      if (sample_valid && (state_q != ACCUM)) overrun_q <= 1'b1;

      if (clear)       frame_cnt_q <= '0;
      else if (acc_en) frame_cnt_q <= frame_cnt_q + CNT_W'(1);

      if (scan_en) lag_idx_q <= (lag_idx_q == IDX_W'(NLAG - 1)) ? '0 : lag_idx_q + IDX_W'(1);

      if (load_out) begin
        for (int k = 0; k < MIC_NUM; k++) lag_q[k] <= LAG_W'(int'(best_idx[k]) - MAX_LAG);
      end
    end
  end

  assign lag_diff = lag_q;
  assign ena      = ena_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_tdoa_lag_estimator.sv
module tb_tdoa_lag_estimator;
  import tdoa_pkg::*;

  localparam int SW = 16;
  localparam int M  = 6;
  localparam int FL = 1024;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    sample_valid = 1'b0;
  logic                    pos_ready = 1'b1;
  logic signed [SW-1:0]    mic_ref = '0;
  logic signed [SW-1:0]    mic_data [0:MIC_NUM-1];
  logic signed [LAG_W-1:0] lag_diff [0:MIC_NUM-1];
  logic                    ena, busy, overrun;

  tdoa_lag_estimator #(.SW(SW), .MAX_LAG(M), .FRAME_LEN(FL)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .mic_ref      (mic_ref),
    .mic_data     (mic_data),
    .pos_ready    (pos_ready),
    .lag_diff     (lag_diff),
    .ena          (ena),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[i] holds the sign bits of strobe i since the last reset:
  // bit 0 = reference, bit k+1 = mic k. Before the first strobe all signs are 0.
  logic [MIC_NUM:0] hist[$];
  int               acc_idx[$];   // strobes accepted into the current frame

  typedef struct packed {
    logic [MIC_NUM-1:0][31:0] lag;
    logic signed [31:0]       edge_no;  // -1: latency not checked
  } exp_t;
  exp_t sb_q[$];

  function automatic bit sgn(input int idx, input int b);
    if (idx < 0) return 1'b0;
    return hist[idx][b];
  endfunction

  // Lag with the highest agreement count; ties go to the most negative lag.
  function automatic int best_lag(input int k);
    int best_s;
    int best_l;
    int s;
    int n;
    best_s = -1;
    best_l = 0;
    for (int l = -M; l <= M; l++) begin
      s = 0;
      foreach (acc_idx[j]) begin
        n = acc_idx[j];
        if (sgn(n - M, k + 1) == sgn(n - M - l, 0)) s++;
      end
      if (s > best_s) begin
        best_s = s;
        best_l = l;
      end
    end
    return best_l;
  endfunction

  task automatic push_expect();
    exp_t e;
    for (int k = 0; k < MIC_NUM; k++) e.lag[k] = 32'(best_lag(k));
    // Strobe is accepted at the next edge; ena follows 2*M+2 edges later.
    e.edge_no = pos_ready ? 32'(edge_cnt + 1 + 2 * M + 2) : -32'sd1;
    sb_q.push_back(e);
    acc_idx.delete();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (ena === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ena", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        for (int k = 0; k < MIC_NUM; k++)
          check($sformatf("sb_lag[%0d]", k), longint'(lag_diff[k]), longint'($signed(e.lag[k])));
        if (e.edge_no >= 0) check("ena_latency", edge_cnt, e.edge_no);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic strobe(input int r, input int m [MIC_NUM], input bit accept);
    logic [MIC_NUM:0] h;
    mic_ref = SW'(r);
    h[0] = mic_ref[SW-1];
    for (int k = 0; k < MIC_NUM; k++) begin
      mic_data[k] = SW'(m[k]);
      h[k+1] = mic_data[k][SW-1];
    end
    sample_valid = 1'b1;
    hist.push_back(h);
    if (accept) begin
      acc_idx.push_back(hist.size() - 1);
      if (acc_idx.size() == FL) push_expect();
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  function automatic int noise();
    return int'($urandom_range(2000)) - 1000;
  endfunction

  // mode 0: all mics equal ref; 1: mic k = ref delayed by k-2;
  // 2: everything constant +5; 3: mic 3 = -ref delayed by 4, others noise.
  task automatic run_frame(input int mode, input bit gaps);
    int rs [FL+16];
    int m  [MIC_NUM];
    int r;
    for (int i = 0; i < FL + 16; i++) rs[i] = noise();
    check("busy_in_accum", busy, 0);
    for (int j = 0; j < FL; j++) begin
      if (gaps && ($urandom_range(3) == 0)) begin
        @(posedge clk); #1;
      end
      r = rs[j+8];
      for (int k = 0; k < MIC_NUM; k++) begin
        case (mode)
          0: m[k] = r;
          1: m[k] = rs[j + 8 - (k - 2)];
          2: m[k] = 5;
          default: m[k] = (k == 3) ? -rs[j + 8 - 4] : noise();
        endcase
      end
      if (mode == 2) r = 5;
      strobe(r, m, 1'b1);
    end
    check("busy_after_frame", busy, 1);
  endtask

  task automatic wait_ena(input int budget);
    int n;
    n = 0;
    while (ena !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("ena_seen", (ena === 1'b1), 1);
    @(posedge clk); #1;
  endtask

  task automatic check_lags(input string tag, input int l0, input int l1, input int l2,
                            input int l3, input int l4, input int l5);
    int exp_l [MIC_NUM];
    exp_l = '{l0, l1, l2, l3, l4, l5};
    for (int k = 0; k < MIC_NUM; k++)
      check($sformatf("%s[%0d]", tag, k), longint'(lag_diff[k]), exp_l[k]);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < MIC_NUM; k++)
      check($sformatf("%s_lag[%0d]", tag, k), longint'(lag_diff[k]), 0);
    check({tag, "_ena"}, ena, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    int m [MIC_NUM];
    for (int k = 0; k < MIC_NUM; k++) mic_data[k] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Constant input: every lag ties at FL, most negative lag wins.
    run_frame(2, 1'b0);
    wait_ena(40);
    check_lags("const_tie", -M, -M, -M, -M, -M, -M);

    // Identical mics with random idle gaps between strobes.
    run_frame(0, 1'b1);
    wait_ena(40);
    check_lags("equal", 0, 0, 0, 0, 0, 0);

    // Staggered delays.
    run_frame(1, 1'b0);
    wait_ena(40);
    check_lags("delayed", -2, -1, 0, 1, 2, 3);

    // Downstream stalled; strobes during WAIT are dropped and flagged.
    check("overrun_clear", overrun, 0);
    pos_ready = 1'b0;
    run_frame(0, 1'b0);
    repeat (2 * M + 1) @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 3) begin
        for (int k = 0; k < MIC_NUM; k++) m[k] = noise();
        strobe(noise(), m, 1'b0);
      end else begin
        @(posedge clk); #1;
      end
    end
    check("stall_no_ena", ena, 0);
    check("stall_busy", busy, 1);
    check("overrun_set", overrun, 1);
    pos_ready = 1'b1;
    @(negedge clk);
    check("ena_before_ready_edge", ena, 0);
    @(negedge clk);
    check("ena_after_ready", ena, 1);
    @(posedge clk); #1;
    run_frame(1, 1'b0);
    wait_ena(40);
    check_lags("after_stall", -2, -1, 0, 1, 2, 3);
    check("overrun_sticky", overrun, 1);

    // Reset mid-frame: partial frame discarded, fresh full frame required.
    for (int j = 0; j < 500; j++) begin
      for (int k = 0; k < MIC_NUM; k++) m[k] = noise();
      strobe(noise(), m, 1'b1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hist.delete();
    acc_idx.delete();
    check_reset_outputs("midrst");
    run_frame(0, 1'b0);
    wait_ena(40);
    check_lags("post_rst", 0, 0, 0, 0, 0, 0);

    // Inverted, delayed mic 3: scoreboard model decides the expected lags.
    run_frame(3, 1'b1);
    wait_ena(40);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
